// File: rtl/eth_tx_arbiter_if.sv
// Engine-side bundle between eth_tx_arbiter (master) and the RGMII transmit engine (slave).
// Carries the start/busy handshake and the per-frame parameters latched by the arbiter.
interface eth_tx_arbiter_if;
  logic        i_eth_tx_busy;
  logic        o_eth_tx_start;
  logic [15:0] o_eth_tx_size;
  logic        o_eth_tx_lfsr_enable;
  logic [7:0]  o_gap_count;

  modport master (
    input  i_eth_tx_busy,
    output o_eth_tx_start,
    output o_eth_tx_size,
    output o_eth_tx_lfsr_enable,
    output o_gap_count
  );

  modport slave (
    output i_eth_tx_busy,
    input  o_eth_tx_start,
    input  o_eth_tx_size,
    input  o_eth_tx_lfsr_enable,
    input  o_gap_count
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Round-robin scheduler sharing one RGMII TX engine among NUM_REQ frame sources.
// Define ETH_TX_ARB_STATS_EN to add saturating frame and timeout counters.
module eth_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int START_HOLD   = 4,
  parameter int BUSY_TIMEOUT = 64,
  parameter int IDX_W        = 2
) (
  input  logic                   i_eth_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [16*NUM_REQ-1:0]  i_size,
  input  logic [NUM_REQ-1:0]     i_lfsr_mode,
  input  logic [7:0]             i_gap_cfg,
  eth_tx_arbiter_if.master       tx,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic [IDX_W-1:0]       o_mem_sel,
  output logic [NUM_REQ-1:0]     o_done,
  output logic [NUM_REQ-1:0]     o_timeout
`ifdef ETH_TX_ARB_STATS_EN
  ,
  output logic [31:0]            o_frame_cnt,
  output logic [15:0]            o_timeout_cnt
`endif
);

  localparam int CNT_MAX = (BUSY_TIMEOUT > START_HOLD) ? BUSY_TIMEOUT : START_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   rr_ptr_q;

  logic               start_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   sel_q;
  logic [15:0]        size_q;
  logic               lfsr_q;
  logic [7:0]         gap_q;
  logic [NUM_REQ-1:0] done_q;
  logic [NUM_REQ-1:0] timeout_q;

  logic               arb_fire;
  logic               done_fire;
  logic               timeout_fire;

  // Round-robin pick: first requester at or above rr_ptr, wrapping.
  int                 cand;
  logic [IDX_W-1:0]   cand_idx;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic [15:0]        pick_size;
  logic               pick_lfsr;

  // NOTE: every variable driven here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cand       = 0;
    cand_idx   = '0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand     = (int'(rr_ptr_q) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!pick_valid && i_req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    pick_grant = '0;
    pick_size  = '0;
    pick_lfsr  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == IDX_W'(k)) begin
        pick_grant[k] = 1'b1;
        pick_size     = i_size[16*k +: 16];
        pick_lfsr     = i_lfsr_mode[k];
      end
    end
  end

  always_ff @(posedge i_eth_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The shared counter times the start hold in START and the busy wait in WAIT_BUSY.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    arb_fire     = 1'b0;
    done_fire    = 1'b0;
    timeout_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid && !tx.i_eth_tx_busy) begin
          arb_fire = 1'b1;
          state_d  = START;
          cnt_d    = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_W'(START_HOLD - 1)) begin
          state_d = WAIT_BUSY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_BUSY: begin
        // Busy wins over an expiring counter in the same cycle.
        if (tx.i_eth_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          timeout_fire = 1'b1;
          state_d      = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx.i_eth_tx_busy) begin
          done_fire = 1'b1;
          state_d   = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the frame registers are reset as well, because every output must read
  // zero while i_rst_n is low, including mid-frame.
  always_ff @(posedge i_eth_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      start_q   <= 1'b0;
      grant_q   <= '0;
      sel_q     <= '0;
      size_q    <= '0;
      lfsr_q    <= 1'b0;
      gap_q     <= '0;
      done_q    <= '0;
      timeout_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees pre-edge values regardless of statement order.
      start_q   <= (state_d == START);
      done_q    <= done_fire ? grant_q : '0;
      timeout_q <= timeout_fire ? grant_q : '0;
      if (arb_fire) begin
        grant_q <= pick_grant;
        sel_q   <= pick_idx;
        size_q  <= pick_size;
        lfsr_q  <= pick_lfsr;
        gap_q   <= i_gap_cfg;
      end
      // o_mem_sel deliberately keeps the last granted index after release.
      if (state_q == RELEASE) begin
        grant_q  <= '0;
        rr_ptr_q <= (sel_q == IDX_W'(NUM_REQ - 1)) ? '0 : sel_q + IDX_W'(1);
      end
    end
  end

`ifdef ETH_TX_ARB_STATS_EN
  logic [31:0] frame_cnt_q;
  logic [15:0] timeout_cnt_q;

  always_ff @(posedge i_eth_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt_q   <= '0;
      timeout_cnt_q <= '0;
    end else begin
      if (done_fire && !(&frame_cnt_q)) frame_cnt_q <= frame_cnt_q + 32'd1;
      if (timeout_fire && !(&timeout_cnt_q)) timeout_cnt_q <= timeout_cnt_q + 16'd1;
    end
  end

  assign o_frame_cnt   = frame_cnt_q;
  assign o_timeout_cnt = timeout_cnt_q;
`endif

  assign tx.o_eth_tx_start       = start_q;
  assign tx.o_eth_tx_size        = size_q;
  assign tx.o_eth_tx_lfsr_enable = lfsr_q;
  assign tx.o_gap_count          = gap_q;
  assign o_grant                 = grant_q;
  assign o_mem_sel               = sel_q;
  assign o_done                  = done_q;
  assign o_timeout               = timeout_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: table of whole-frame vectors plus hand-written
// sequences for busy blocking and mid-frame reset.
module tb_eth_tx_arbiter;

  localparam logic [63:0] SIZES = {16'd40, 16'd1500, 16'd100, 16'd64};
  localparam logic [3:0]  LFSR  = 4'b1010;
  localparam logic [7:0]  GAP   = 8'd12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] size;
  logic [3:0]  lfsr_mode;
  logic [7:0]  gap_cfg;
  logic [3:0]  grant;
  logic [1:0]  mem_sel;
  logic [3:0]  done;
  logic [3:0]  timeout;
`ifdef ETH_TX_ARB_STATS_EN
  logic [31:0] frame_cnt;
  logic [15:0] timeout_cnt;
`endif

  always #5 clk = ~clk;

  eth_tx_arbiter_if tx_if ();

  eth_tx_arbiter #(
    .NUM_REQ      (4),
    .START_HOLD   (4),
    .BUSY_TIMEOUT (64),
    .IDX_W        (2)
  ) dut (
    .i_eth_clk   (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_size      (size),
    .i_lfsr_mode (lfsr_mode),
    .i_gap_cfg   (gap_cfg),
    .tx          (tx_if),
    .o_grant     (grant),
    .o_mem_sel   (mem_sel),
    .o_done      (done),
    .o_timeout   (timeout)
`ifdef ETH_TX_ARB_STATS_EN
    ,
    .o_frame_cnt   (frame_cnt),
    .o_timeout_cnt (timeout_cnt)
`endif
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    int          busy_delay;  // cycles after start rise that busy rises, -1 = never
    int          busy_len;
    int          churn_k;     // cycle at which inputs are scrambled, -1 = never
    logic [3:0]  exp_grant;
    logic [1:0]  exp_sel;
    logic [15:0] exp_size;
    logic        exp_lfsr;
    logic [3:0]  exp_done;
    logic [3:0]  exp_to;
    int          exp_k;       // cycle after start rise when done/timeout is seen
  } vec_t;

  vec_t vecs [10];

  task automatic run_vec(input vec_t v, input int id);
    int          lat;
    int          start_cycles;
    int          pulse_cycles;
    int          event_k;
    logic [3:0]  done_acc;
    logic [3:0]  to_acc;
    logic [3:0]  cap_grant;
    logic [1:0]  cap_sel;
    logic [15:0] cap_size;
    logic        cap_lfsr;
    logic [7:0]  cap_gap;
    bit          stable;
    bit          ended;

    req = v.req;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!tx_if.o_eth_tx_start && lat < 20);
    check($sformatf("v%0d start_latency", id), lat, 1);

    cap_grant = grant;
    cap_sel   = mem_sel;
    cap_size  = tx_if.o_eth_tx_size;
    cap_lfsr  = tx_if.o_eth_tx_lfsr_enable;
    cap_gap   = tx_if.o_gap_count;
    check($sformatf("v%0d grant", id), cap_grant, v.exp_grant);
    check($sformatf("v%0d mem_sel", id), cap_sel, v.exp_sel);
    check($sformatf("v%0d size", id), cap_size, v.exp_size);
    check($sformatf("v%0d lfsr", id), cap_lfsr, v.exp_lfsr);
    check($sformatf("v%0d gap", id), cap_gap, GAP);

    start_cycles = 0;
    pulse_cycles = 0;
    event_k      = -1;
    done_acc     = '0;
    to_acc       = '0;
    stable       = 1'b1;
    ended        = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (tx_if.o_eth_tx_start) start_cycles++;
      if ((done | timeout) != 4'b0) begin
        pulse_cycles++;
        if (event_k < 0) event_k = k;
      end
      done_acc |= done;
      to_acc   |= timeout;
      if (grant != 4'b0 && (grant !== cap_grant || mem_sel !== cap_sel ||
          tx_if.o_eth_tx_size !== cap_size || tx_if.o_eth_tx_lfsr_enable !== cap_lfsr ||
          tx_if.o_gap_count !== cap_gap))
        stable = 1'b0;
      if (event_k >= 0 && grant == 4'b0) begin
        ended = 1'b1;
        break;
      end
      tx_if.i_eth_tx_busy = (v.busy_delay >= 0) && (k >= v.busy_delay) &&
                            (k < v.busy_delay + v.busy_len);
      if (k == v.churn_k) begin
        size      = ~SIZES;
        lfsr_mode = ~LFSR;
        gap_cfg   = 8'hA5;
        req       = 4'b0;
      end
      @(negedge clk);
    end
    tx_if.i_eth_tx_busy = 1'b0;
    size      = SIZES;
    lfsr_mode = LFSR;
    gap_cfg   = GAP;

    check($sformatf("v%0d frame_ended", id), 32'(ended), 1);
    check($sformatf("v%0d start_cycles", id), start_cycles, 4);
    check($sformatf("v%0d done", id), done_acc, v.exp_done);
    check($sformatf("v%0d timeout", id), to_acc, v.exp_to);
    check($sformatf("v%0d event_cycle", id), event_k, v.exp_k);
    check($sformatf("v%0d pulse_width", id), pulse_cycles, 1);
    check($sformatf("v%0d latched_stable", id), 32'(stable), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " start"}, 32'(tx_if.o_eth_tx_start), 0);
    check({tag, " grant"}, grant, 0);
    check({tag, " mem_sel"}, mem_sel, 0);
    check({tag, " size"}, tx_if.o_eth_tx_size, 0);
    check({tag, " lfsr"}, 32'(tx_if.o_eth_tx_lfsr_enable), 0);
    check({tag, " gap"}, tx_if.o_gap_count, 0);
    check({tag, " done"}, done, 0);
    check({tag, " timeout"}, timeout, 0);
`ifdef ETH_TX_ARB_STATS_EN
    check({tag, " frame_cnt"}, frame_cnt, 0);
    check({tag, " timeout_cnt"}, 32'(timeout_cnt), 0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         blocked_ok;
    logic [3:0] pulses;

    vecs[0] = '{4'b1111,  3,  10, -1, 4'b0001, 2'd0, 16'd64,   1'b0, 4'b0001, 4'b0000,  14};
    vecs[1] = '{4'b1111,  3,  10, -1, 4'b0010, 2'd1, 16'd100,  1'b1, 4'b0010, 4'b0000,  14};
    vecs[2] = '{4'b1111,  3,  10, -1, 4'b0100, 2'd2, 16'd1500, 1'b0, 4'b0100, 4'b0000,  14};
    vecs[3] = '{4'b1111,  3,  10, -1, 4'b1000, 2'd3, 16'd40,   1'b1, 4'b1000, 4'b0000,  14};
    vecs[4] = '{4'b1111,  3,  10, -1, 4'b0001, 2'd0, 16'd64,   1'b0, 4'b0001, 4'b0000,  14};
    vecs[5] = '{4'b0010,  5, 200, -1, 4'b0010, 2'd1, 16'd100,  1'b1, 4'b0010, 4'b0000, 206};
    vecs[6] = '{4'b0100, -1,   0, -1, 4'b0100, 2'd2, 16'd1500, 1'b0, 4'b0000, 4'b0100,  68};
    vecs[7] = '{4'b1111,  3,  10, -1, 4'b1000, 2'd3, 16'd40,   1'b1, 4'b1000, 4'b0000,  14};
    vecs[8] = '{4'b0001, 67,   5, -1, 4'b0001, 2'd0, 16'd64,   1'b0, 4'b0001, 4'b0000,  73};
    vecs[9] = '{4'b0010,  5,  60, 30, 4'b0010, 2'd1, 16'd100,  1'b1, 4'b0010, 4'b0000,  66};

    rst_n               = 1'b0;
    req                 = 4'b1111;
    size                = SIZES;
    lfsr_mode           = LFSR;
    gap_cfg             = GAP;
    tx_if.i_eth_tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
    req = 4'b0;

`ifdef ETH_TX_ARB_STATS_EN
    check("stats frame_cnt", frame_cnt, 9);
    check("stats timeout_cnt", 32'(timeout_cnt), 1);
`endif

    // Engine busy (PLL unlocked) blocks arbitration entirely.
    tx_if.i_eth_tx_busy = 1'b1;
    req                 = 4'b0001;
    blocked_ok          = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (tx_if.o_eth_tx_start || grant != 4'b0) blocked_ok = 1'b0;
    end
    check("blocked no_start_no_grant", 32'(blocked_ok), 1);
    tx_if.i_eth_tx_busy = 1'b0;
    @(negedge clk);
    check("unblocked start", 32'(tx_if.o_eth_tx_start), 1);
    check("unblocked grant", grant, 4'b0001);

    // Drive the frame into WAIT_DONE, then reset asynchronously mid-cycle.
    repeat (4) @(negedge clk);
    tx_if.i_eth_tx_busy = 1'b1;
    repeat (10) @(negedge clk);
    check("midframe grant", grant, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tx_if.i_eth_tx_busy = 1'b0;
    pulses = '0;
    repeat (3) begin
      @(negedge clk);
      pulses |= done | timeout;
    end
    check("reset no_pulse", pulses, 0);

    // rr_ptr was 2 before reset; a reset pointer serves requester 0 first.
    rst_n = 1'b1;
    req   = 4'b1111;
    @(negedge clk);
    check("post_reset start", 32'(tx_if.o_eth_tx_start), 1);
    check("post_reset rr_grant", grant, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
Round-robin scheduler that shares one RGMII transmit engine (eth_tx_fsm) between NUM_REQ frame sources. It selects a requester and latches its frame size and LFSR mode. It then issues a level start pulse long enough for the engine's 3-flop start synchronizer and edge detector, and tracks the engine's busy flag through the whole frame. It returns a per-requester done or timeout pulse, and drives the select for the external TX memory read-data mux.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
START_HOLD, 4, cycles o_eth_tx_start is held high (min 3)
BUSY_TIMEOUT, 64, cycles to wait for busy to assert after start before aborting
IDX_W, 2, width of requester index (clog2(NUM_REQ), min 1)

Ports:
i_eth_clk  in  1  transmit clock, all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req  in  NUM_REQ  per-requester frame request, level, held until done/timeout
i_size  in  16*NUM_REQ  per-requester payload size, slice k = [16k+15:16k]
i_lfsr_mode  in  NUM_REQ  per-requester LFSR test-pattern select
i_gap_cfg  in  8  inter-frame gap passed to engine
i_eth_tx_busy  in  1  engine busy (also high while engine PLL unlocked)
o_eth_tx_start  out  1  start to engine
o_eth_tx_size  out  16  latched size of granted requester
o_eth_tx_lfsr_enable  out  1  latched LFSR mode of granted requester
o_gap_count  out  8  latched i_gap_cfg
o_grant  out  NUM_REQ  one-hot grant, held from ARB exit to RELEASE
o_mem_sel  out  IDX_W  binary index of granted requester
o_done  out  NUM_REQ  one-cycle pulse on the granted bit at frame completion
o_timeout  out  NUM_REQ  one-cycle pulse on the granted bit when busy never asserted

Behaviour:
- Reset (async assert, sync deassert expected upstream) forces the following:
  - state IDLE
  - all outputs 0
  - round-robin pointer rr_ptr = 0
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, RELEASE.
- IDLE:
  - Arbitration requires |i_req and i_eth_tx_busy==0.
  - Pick the first set i_req bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Latch, in the same edge, o_grant, o_mem_sel, o_eth_tx_size (from that slice), o_eth_tx_lfsr_enable and o_gap_count.
  - Go to START with hold counter = 0.
  - If busy is high (engine active or PLL unlocked), stay in IDLE with no grant.
- START:
  - o_eth_tx_start = 1 for exactly START_HOLD cycles, then 0.
  - Go to WAIT_BUSY; the timeout counter resets to 0 on entry.
- WAIT_BUSY:
  - On i_eth_tx_busy==1 go to WAIT_DONE.
  - If the counter reaches BUSY_TIMEOUT-1 without busy, pulse the o_timeout bit and go to RELEASE (the o_done bit is not pulsed).
  - Busy rising in the same cycle the counter expires counts as success: go to WAIT_DONE, no timeout.
- WAIT_DONE: on i_eth_tx_busy==0, pulse the o_done bit (one cycle) and go to RELEASE. There is no timeout in this state.
- RELEASE (one cycle):
  - Clear o_grant; o_mem_sel holds its value.
  - rr_ptr = granted index + 1, wrapping NUM_REQ-1 -> 0.
  - Return to IDLE.
  - Minimum gap between consecutive starts is one IDLE cycle.
- Latched size/mode/gap are stable from START until RELEASE; input changes during a frame are ignored.
- Requester deasserting i_req mid-frame does not abort; the frame completes and o_done is still pulsed.
- Reset mid-frame drops o_eth_tx_start and o_grant immediately; no done or timeout pulse.
- Size is passed unmodified; the engine applies its own 60-byte minimum.
- Latency from i_req rise (busy low, IDLE) to o_eth_tx_start rise is 1 cycle.

Optional Feature:
ETH_TX_ARB_STATS_EN:
- When defined, adds outputs o_frame_cnt (32 bits, total frames completed via done) and o_timeout_cnt (16 bits, total timeouts). Both saturate at all-ones, and both reset to 0 on i_rst_n.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Single request: i_req=4'b0010, size=100, busy model rises 5 cycles after start and stays high 200 cycles -> the following, exactly once:
  - o_grant=0010, o_mem_sel=1, o_eth_tx_size=100
  - start high 4 cycles
  - o_done=0010 pulse one cycle after busy falls
- Round robin: i_req=4'b1111 held for 5 frames -> grant order 0001, 0010, 0100, 1000, 0001. Each size latched from its own slice.
- Timeout: busy never asserts -> o_timeout pulses on the granted bit at cycle 4+64 after start rise, o_done stays 0, next requester served.
- Busy-blocked: i_eth_tx_busy held 1 (PLL unlocked), i_req=0001 -> no start, no grant. Busy drops -> start begins 1 cycle later.
- Mid-frame input churn: size/lfsr/gap inputs change and i_req drops during WAIT_DONE -> outputs stay latched, o_done still pulses.
- Reset mid-frame: assert i_rst_n=0 in WAIT_DONE -> all outputs 0 asynchronously, rr_ptr=0. With STATS_EN, counters = 0.
